// File: rtl/seq_abcd_monitor.sv
// rtl/seq_abcd_monitor.sv - overlapping checker for a ##1 b ##1 c ##2 d with saturating pass/fail counters
// One token per pipeline stage; each edge may start a new attempt, so up to five attempts are in flight.
module seq_abcd_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             pass,
    output logic [3:0]       fail_vec,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic             s1;
    logic             s2;
    logic             s3;
    logic             s4;
    logic [3:0]       fail_ev;
    logic             pass_ev;
    logic [2:0]       fail_pop;
    logic [CNT_W:0]   fail_sum;
    logic [CNT_W:0]   pass_sum;

    // Every stage resolves independently, so several fail bits can fire on one edge.
    always_comb begin
        fail_ev  = {s4 & ~d, s2 & ~c, s1 & ~b, en & ~a};
        pass_ev  = s4 & d;
        fail_pop = {2'b00, fail_ev[0]} + {2'b00, fail_ev[1]}
                 + {2'b00, fail_ev[2]} + {2'b00, fail_ev[3]};
        fail_sum = {1'b0, fail_cnt} + {{(CNT_W-2){1'b0}}, fail_pop};
        pass_sum = {1'b0, pass_cnt} + {{CNT_W{1'b0}}, pass_ev};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            s4       <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= 4'b0000;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            s1       <= en & a;
            s2       <= s1 & b;
            s3       <= s2 & c;
            s4       <= s3;
            pass     <= pass_ev;
            fail_vec <= fail_ev;
            // clr drops same-edge events from the counts but not from the pulses
            if (clr) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
            end else begin
                pass_cnt <= (pass_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : pass_sum[CNT_W-1:0];
                fail_cnt <= (fail_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : fail_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_abcd_monitor.sv
// tb/tb_seq_abcd_monitor.sv - directed and random bench for seq_abcd_monitor against an input-history model
module tb_seq_abcd_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        pass;
    logic [3:0]  fail_vec;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic        pass4;
    logic [3:0]  fail_vec4;
    logic [3:0]  pass_cnt4;
    logic [3:0]  fail_cnt4;

    int n_checks;
    int n_fails;

    // history of sampled inputs; index 0 is the edge just taken, index k is k edges earlier
    logic h_v[5];
    logic h_en[5];
    logic h_a[5];
    logic h_b[5];
    logic h_c[5];
    logic h_d[5];

    int m_pass;
    int m_fv;
    int m_pc;
    int m_fc;
    int m_pc4;
    int m_fc4;

    seq_abcd_monitor dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .a(a), .b(b), .c(c), .d(d),
        .pass(pass), .fail_vec(fail_vec), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    seq_abcd_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .a(a), .b(b), .c(c), .d(d),
        .pass(pass4), .fail_vec(fail_vec4), .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_add(input int cur, input int inc, input int max);
        return (cur + inc > max) ? max : cur + inc;
    endfunction

    task automatic model_edge();
        int f0;
        int f1;
        int f2;
        int f3;
        int ok4;
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) h_v[i] = 1'b0;
            m_pass = 0; m_fv = 0; m_pc = 0; m_fc = 0; m_pc4 = 0; m_fc4 = 0;
            return;
        end
        for (int i = 4; i > 0; i--) begin
            h_v[i] = h_v[i-1]; h_en[i] = h_en[i-1]; h_a[i] = h_a[i-1];
            h_b[i] = h_b[i-1]; h_c[i] = h_c[i-1]; h_d[i] = h_d[i-1];
        end
        h_v[0] = 1'b1; h_en[0] = en; h_a[0] = a; h_b[0] = b; h_c[0] = c; h_d[0] = d;
        // attempts started 0, 1, 2 and 4 edges ago are decided on this edge
        f0  = (h_en[0] && !h_a[0]) ? 1 : 0;
        f1  = (h_v[1] && h_en[1] && h_a[1] && !h_b[0]) ? 1 : 0;
        f2  = (h_v[2] && h_en[2] && h_a[2] && h_b[1] && !h_c[0]) ? 1 : 0;
        ok4 = (h_v[4] && h_en[4] && h_a[4] && h_b[3] && h_c[2]) ? 1 : 0;
        f3  = (ok4 != 0 && !h_d[0]) ? 1 : 0;
        m_pass = (ok4 != 0 && h_d[0]) ? 1 : 0;
        m_fv   = f0 + 2 * f1 + 4 * f2 + 8 * f3;
        if (clr) begin
            m_pc = 0; m_fc = 0; m_pc4 = 0; m_fc4 = 0;
        end else begin
            m_pc  = sat_add(m_pc,  m_pass, 65535);
            m_fc  = sat_add(m_fc,  f0 + f1 + f2 + f3, 65535);
            m_pc4 = sat_add(m_pc4, m_pass, 15);
            m_fc4 = sat_add(m_fc4, f0 + f1 + f2 + f3, 15);
        end
    endtask

    task automatic compare_all();
        chk("pass",      int'(pass),      m_pass);
        chk("fail_vec",  int'(fail_vec),  m_fv);
        chk("pass_cnt",  int'(pass_cnt),  m_pc);
        chk("fail_cnt",  int'(fail_cnt),  m_fc);
        chk("pass4",     int'(pass4),     m_pass);
        chk("fail_vec4", int'(fail_vec4), m_fv);
        chk("pass_cnt4", int'(pass_cnt4), m_pc4);
        chk("fail_cnt4", int'(fail_cnt4), m_fc4);
    endtask

    task automatic step(input logic i_en, input logic i_a, input logic i_b, input logic i_c,
                        input logic i_d, input logic i_clr, input logic i_rst_n);
        @(negedge clk);
        en = i_en; a = i_a; b = i_b; c = i_c; d = i_d; clr = i_clr; rst_n = i_rst_n;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 5; i++) h_v[i] = 1'b0;
        m_pass = 0; m_fv = 0; m_pc = 0; m_fc = 0; m_pc4 = 0; m_fc4 = 0;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;
        #2;
        chk("reset_pass",     int'(pass),     0);
        chk("reset_fail_vec", int'(fail_vec), 0);
        chk("reset_fail_cnt", int'(fail_cnt), 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // single good attempt: a,b,c,x,d = 1,1,1,0,1
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("good_pass",     int'(pass),     1);
        chk("good_pass_cnt", int'(pass_cnt), 1);
        chk("good_fail_cnt", int'(fail_cnt), 0);
        idle(1);
        chk("good_pass_one_cycle", int'(pass), 0);

        // all-zero inputs with en held: one a-failure per edge
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("zero_fail_vec", int'(fail_vec), 1);
        end
        chk("zero_fail_cnt", int'(fail_cnt), 10);
        idle(4);

        // two attempts failing on b and c on the same edge
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("multi_fail_vec", int'(fail_vec), 6);
        chk("multi_fail_cnt", int'(fail_cnt), 2);
        idle(4);

        // saturation of the 4-bit counters
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 14) chk("sat_reach_15", int'(fail_cnt4), 15);
        end
        chk("sat_hold_15", int'(fail_cnt4), 15);
        chk("sat_wide_20", int'(fail_cnt), 20);
        idle(4);

        // reset mid-attempt: outputs clear at once, attempt is abandoned
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_pass",     int'(pass),     0);
        chk("rst_async_fail_vec", int'(fail_vec), 0);
        chk("rst_async_fail_cnt", int'(fail_cnt), 0);
        chk("rst_async_pass_cnt", int'(pass_cnt), 0);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            chk("rst_no_fail", int'(fail_vec), 0);
        end
        chk("rst_no_pass_cnt", int'(pass_cnt), 0);

        // clr on the same edge as an a-failure
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_pre_fail_cnt", int'(fail_cnt), 5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_fail_cnt", int'(fail_cnt), 0);
        chk("clr_fail_vec", int'(fail_vec), 1);
        idle(4);

        // random traffic, biased towards 1 so passes occur
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 150) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/seq_abcd_monitor.md
SEQ_ABCD_MONITOR -- requirements
Module: seq_abcd_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the pass and fail event counters (legal range 4..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port en  input  1  when high, a new check attempt starts on the current edge.
REQ-005 SHALL have port clr  input  1  synchronous clear of both counters.
REQ-006 SHALL have ports a, b, c, d  input  1 each  monitored signals, sampled on the rising edge of clk.
REQ-007 SHALL have port pass  output  1  one-cycle pulse: an attempt completed a ##1 b ##1 c ##2 d.
REQ-008 SHALL have port fail_vec  output  4  one-cycle flags; bit0 = attempt failed on a, bit1 = on b, bit2 = on c, bit3 = on d.
REQ-009 SHALL have port pass_cnt  output  CNT_W  saturating count of pass events.
REQ-010 SHALL have port fail_cnt  output  CNT_W  saturating count of failed attempts.

Function
REQ-011 SHALL check the sequence a@t, b@t+1, c@t+2, d@t+4 over edge indices t. Any value of the signal at t+3 is acceptable.
REQ-012 SHALL start one independent attempt at every edge where en=1, so up to 5 attempts overlap, one per stage.
REQ-013 SHALL track attempts with a 4-entry token pipeline: S1 (a seen), S2 (b seen), S3 (c seen), S4 (wait slot done). Each token advances one stage per edge.
REQ-014 Stage 0 (new attempt): a=1 SHALL set S1, and a=0 SHALL flag fail_vec[0].
REQ-015 Stage S1: b=1 SHALL advance the token to S2, and b=0 SHALL drop it and flag fail_vec[1].
REQ-016 Stage S2: c=1 SHALL advance the token to S3, and c=0 SHALL drop it and flag fail_vec[2].
REQ-017 S3 SHALL always advance to S4.
REQ-018 Stage S4: d=1 SHALL pulse pass, and d=0 SHALL flag fail_vec[3]. The token then retires in either case.
REQ-019 pass and fail_vec SHALL be registered and valid in the cycle after the deciding edge. They SHALL be held high for exactly one cycle per event.
REQ-020 Several fail_vec bits SHALL be settable in the same cycle, and pass together with fail bits, because attempts in different stages resolve independently.
REQ-021 fail_cnt SHALL add popcount(fail_vec event bits) and pass_cnt SHALL add the pass event, both on the same edge that registers the event.
REQ-022 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 With en=0, no new attempt SHALL start and fail_vec[0] SHALL NOT be flagged. In-flight tokens SHALL continue to completion.
REQ-024 clr=1 SHALL zero both counters on that edge. Events resolved on the same edge SHALL be discarded, so clr wins. Tokens SHALL be unaffected.

Reset
REQ-025 rst_n=0 SHALL immediately clear all tokens, pass, fail_vec, pass_cnt and fail_cnt to 0, independent of clk.
REQ-026 Reset asserted mid-attempt SHALL abandon all in-flight attempts with no pass or fail reported.
REQ-027 After rst_n rises, the first attempt SHALL start on the first rising edge with en=1.

Verification
REQ-028 Bench SHALL cover: en=1 for one edge, then en=0; a,b,c,x,d = 1,1,1,0,1 on edges 0..4. Required: pass=1 one cycle after edge 4, pass_cnt=1, fail_cnt=0, fail_vec stays 0.
REQ-029 Bench SHALL cover: en=1 continuously, a=0,b=0,c=0,d=0 for 10 edges. Required: fail_vec=0001 every cycle and fail_cnt=10.
REQ-030 Bench SHALL cover: en=1 on edges 0 and 1 only; a=1@0, b=1@1, a=1@1, b=0@2, c=0@2. Required: fail_vec=0110 one cycle after edge 2 and fail_cnt=2.
REQ-031 Bench SHALL cover: CNT_W=4, en=1, a=0 for 20 edges. Required: fail_cnt saturates at 15 and holds 15.
REQ-032 Bench SHALL cover: valid attempt started, rst_n pulsed low after edge 2. Required: all outputs 0 immediately, and no pass or fail follows.
REQ-033 Bench SHALL cover: clr=1 on the edge where a fail_vec[0] event resolves with fail_cnt=5. Required: fail_cnt=0 the next cycle, while the fail_vec pulse still appears.
